seg_sampler: RTL

Receive-side counterpart of the `seven_seg` encoder. The block samples a 7-bit segment bus driven by an encoder or an external display pad, waits until the pattern has been stable long enough, and decodes it back to a 4-bit hex digit. Each digit is delivered once on a valid/ready handshake. Patterns outside the code table are reported and counted. It is used in the whack-a-mole bench/loopback path to close the loop on the display datapath.

---
 rtl/seg_pkg.sv | 39 +++
 rtl/seg_sync.sv | 28 ++
 rtl/seg_sampler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment sampler: code table, lookup helper
// and FSM state encoding.
package seg_pkg;

    localparam int SEG_W = 7;

    // Digit index -> {a,b,c,d,e,f,g}; the same table drives the seven_seg encoder.
    localparam logic [SEG_W-1:0] SEG_CODE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef struct packed {
        logic       hit;
        logic       blank;
        logic [3:0] digit;
    } seg_dec_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_EMIT,
        ST_WAIT_CHG
    } seg_state_e;

    function automatic seg_dec_t seg_lookup(input logic [SEG_W-1:0] pattern);
        seg_dec_t res;
        res       = '0;
        res.blank = (pattern == '0);
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_CODE[i]) begin
                res.hit   = 1'b1;
                res.digit = 4'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_sync.sv
// Two-flop synchronizer for a bus that is asynchronous to clk.
module seg_sync #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_out
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_in;
            s2_q <= s1_q;
        end
    end

    assign q_out = s2_q;

endmodule

// File: rtl/seg_sampler.sv
// Samples a seven-segment bus, waits for a stable pattern, decodes it to a hex
// digit and delivers each result once over valid/ready.
module seg_sampler
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SEG_W-1:0] seg_in,
    input  logic             ready_in,
    output logic             valid_out,
    output logic [3:0]       digit_out,
    output logic             blank_out,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

    localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

    logic [SEG_W-1:0] s2;
    seg_dec_t         dec;

    seg_state_e       state_q, state_d;
    logic [SEG_W-1:0] prev_q, prev_d;
    logic [7:0]       stab_q, stab_d;
    logic             valid_q, valid_d;
    logic [3:0]       digit_q, digit_d;
    logic             blank_q, blank_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             busy_q, busy_d;

    seg_sync #(.W(SEG_W)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (seg_in),
        .q_out (s2)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves one unassigned (which would infer a latch).
        dec         = seg_lookup(s2);
        state_d     = state_q;
        prev_d      = prev_q;
        stab_d      = stab_q;
        valid_d     = valid_q;
        digit_d     = digit_q;
        blank_d     = blank_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;

        case (state_q)
            ST_IDLE: begin
                prev_d = '0;
                stab_d = '0;
                if (en) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    prev_d  = '0;
                    stab_d  = '0;
                end else begin
                    prev_d = s2;
                    if (s2 != prev_q) begin
                        stab_d = '0;
                    end else if (stab_q != STAB_LAST) begin
                        stab_d = stab_q + 8'd1;
                    end else begin
                        stab_d = '0;
                        if (dec.hit || dec.blank) begin
                            digit_d = dec.hit ? dec.digit : 4'd0;
                            blank_d = !dec.hit;
                            valid_d = 1'b1;
                            state_d = ST_EMIT;
                        end else begin
                            err_pulse_d = 1'b1;
                            if (!(&err_count_q)) err_count_d = err_count_q + CNT_W'(1);
                            state_d = ST_WAIT_CHG;
                        end
                    end
                end
            end
            ST_EMIT: begin
                // prev_q keeps the emitted pattern so WAIT_CHG compares against it.
                if (ready_in) begin
                    valid_d = 1'b0;
                    if (en) begin
                        state_d = ST_WAIT_CHG;
                    end else begin
                        state_d = ST_IDLE;
                        prev_d  = '0;
                        stab_d  = '0;
                    end
                end
            end
            ST_WAIT_CHG: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    prev_d  = '0;
                    stab_d  = '0;
                end else if (s2 != prev_q) begin
                    state_d = ST_SETTLE;
                    prev_d  = s2;
                    stab_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                prev_d  = '0;
                stab_d  = '0;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prev_q      <= '0;
            stab_q      <= '0;
            valid_q     <= 1'b0;
            digit_q     <= '0;
            blank_q     <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            stab_q      <= stab_d;
            valid_q     <= valid_d;
            digit_q     <= digit_d;
            blank_q     <= blank_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            busy_q      <= busy_d;
        end
    end

    assign valid_out = valid_q;
    assign digit_out = digit_q;
    assign blank_out = blank_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign busy      = busy_q;

endmodule
